// File: rtl/deinterleaver_fsm.sv
// -----------------------------------------------------------------------------
// deinterleaver_fsm
//
// Control FSM and address generator for the LTE turbo deinterleaver. Soft
// symbols arrive in QPP-interleaved order. Beat i is written to RAM address
// pi(i). Each completed block is then read back sequentially 0..K-1, which
// restores natural order. Two external RAM banks are used ping-pong: the
// writer fills one bank while the reader drains the other. This block drives
// only addresses and enables. The datapath is external.
//
// Optional build macro:
//   DEINT_OVF_FLAG_EN - adds the sticky 'ovf' output. It is set by a beat
//                       offered while ready=0, or by a block aborted with
//                       in_start. Only reset clears it.
//
// Ports:
//   clk         in   clock
//   reset       in   asynchronous, active-high reset
//   block_size  in   1: K=6144, 0: K=1056 (sampled on the start beat)
//   in_start    in   first beat of a block (qualified by in_valid)
//   in_valid    in   input beat present
//   ready       out  writer accepts a beat this cycle
//   wr_en       out  RAM write enable
//   wr_bank     out  bank being written
//   wr_addr     out  write address pi(i)
//   rd_en       out  RAM read enable
//   rd_bank     out  bank being read
//   rd_addr     out  sequential read address
//   out_valid   out  RAM read data valid (rd_en delayed one cycle)
//   out_start   out  with the first out_valid of a block
//   out_end     out  with the last out_valid of a block
//   done        out  one-cycle pulse, the cycle after out_end
//   wstate_w    out  writer state (0 idle, 1 run, 2 full)
//   rstate_w    out  reader state (0 idle, 1 run, 2 drain)
//   ovf         out  sticky overflow/abort flag (DEINT_OVF_FLAG_EN only)
// -----------------------------------------------------------------------------
module deinterleaver_fsm #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              block_size,
    input  logic              in_start,
    input  logic              in_valid,
    output logic              ready,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              rd_en,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              out_valid,
    output logic              out_start,
    output logic              out_end,
    output logic              done,
    output logic [1:0]        wstate_w,
    output logic [1:0]        rstate_w
`ifdef DEINT_OVF_FLAG_EN
    ,
    output logic              ovf
`endif
);

    localparam logic [ADDR_W-1:0] K_SMALL  = ADDR_W'(1056);
    localparam logic [ADDR_W-1:0] G0_SMALL = ADDR_W'(83);   // (f1+f2) mod K
    localparam logic [ADDR_W-1:0] D_SMALL  = ADDR_W'(132);  // 2*f2 mod K
    localparam logic [ADDR_W-1:0] K_BIG    = ADDR_W'(6144);
    localparam logic [ADDR_W-1:0] G0_BIG   = ADDR_W'(743);
    localparam logic [ADDR_W-1:0] D_BIG    = ADDR_W'(960);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_RUN = 2'd1, W_FULL = 2'd2} wstate_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_RUN = 2'd1, R_DRAIN = 2'd2} rstate_t;

    // Modular add for operands already reduced below k. A single conditional
    // subtract is enough, so no divider or multiplier is needed.
    function automatic logic [ADDR_W-1:0] mod_add(input logic [ADDR_W-1:0] a,
                                                  input logic [ADDR_W-1:0] b,
                                                  input logic [ADDR_W-1:0] k);
        logic [ADDR_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, k})
            s = s - {1'b0, k};
        return s[ADDR_W-1:0];
    endfunction

    wstate_t wstate, wstate_nxt;
    rstate_t rstate, rstate_nxt;

    logic [1:0]        full, full_nxt;
    logic [1:0]        bank_big;      // per-bank block size, 1 = 6144
    logic              kw_big;
    logic              kr_big;
    logic [ADDR_W-1:0] widx, pi, g;
    logic [ADDR_W-1:0] raddr;
    logic [ADDR_W-1:0] kw, dw, kr;
    logic [ADDR_W-1:0] k_new, g0_new, d_new;
    logic              start_beat, run_beat, last_beat, rd_last;
    logic              vld_p1, sop_p1, eop_p1, done_p2;

    assign kw     = kw_big ? K_BIG : K_SMALL;
    assign dw     = kw_big ? D_BIG : D_SMALL;
    assign kr     = kr_big ? K_BIG : K_SMALL;
    assign k_new  = block_size ? K_BIG : K_SMALL;
    assign g0_new = block_size ? G0_BIG : G0_SMALL;
    assign d_new  = block_size ? D_BIG : D_SMALL;

    // An in_start beat always (re)starts a block at address 0 in the current bank.
    assign start_beat = in_valid & in_start & ready;
    assign run_beat   = in_valid & ~in_start & ready & (wstate == W_RUN);
    assign last_beat  = run_beat & (widx == kw - ADDR_W'(1));
    assign rd_last    = (rstate == R_RUN) & (raddr == kr - ADDR_W'(1));

    // ---------------- writer FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wstate <= W_IDLE;
        else
            wstate <= wstate_nxt;
    end

    always_comb begin
        wstate_nxt = wstate;
        case (wstate)
            W_IDLE: begin
                if (start_beat)
                    wstate_nxt = W_RUN;
                else if (full[wr_bank])
                    wstate_nxt = W_FULL;
            end
            W_RUN: begin
                if (start_beat)
                    wstate_nxt = W_RUN;
                else if (last_beat)
                    // Park in W_FULL when the bank we toggle to is still occupied.
                    wstate_nxt = full[~wr_bank] ? W_FULL : W_IDLE;
            end
            W_FULL: begin
                if (start_beat)
                    wstate_nxt = W_RUN;
                else if (!full[wr_bank])
                    wstate_nxt = W_IDLE;
            end
            default: wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        case (wstate)
            W_IDLE, W_FULL: ready = ~full[wr_bank];
            W_RUN:          ready = 1'b1;
            default:        ready = 1'b0;
        endcase
        if (reset)
            ready = 1'b0;
        wr_en   = start_beat | run_beat;
        wr_addr = run_beat ? pi : '0;
    end

    // ---------------- reader FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rstate <= R_IDLE;
        else
            rstate <= rstate_nxt;
    end

    always_comb begin
        rstate_nxt = rstate;
        case (rstate)
            R_IDLE:  if (full[rd_bank]) rstate_nxt = R_RUN;
            R_RUN:   if (rd_last)       rstate_nxt = R_DRAIN;
            R_DRAIN:                    rstate_nxt = R_IDLE;
            default:                    rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        rd_en   = (rstate == R_RUN);
        rd_addr = (rstate == R_RUN) ? raddr : '0;
    end

    // Set by the writer and cleared by the reader. They never target the same bank in the same cycle.
    always_comb begin
        full_nxt = full;
        for (int b = 0; b < 2; b++) begin
            if (last_beat && (wr_bank == b[0]))
                full_nxt[b] = 1'b1;
            if (rd_last && (rd_bank == b[0]))
                full_nxt[b] = 1'b0;
        end
    end

    // ---------------- stage p0: address generation and bank bookkeeping ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full     <= '0;
            bank_big <= '0;
            kw_big   <= 1'b0;
            kr_big   <= 1'b0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            widx     <= '0;
            pi       <= '0;
            g        <= '0;
            raddr    <= '0;
        end else begin
            full <= full_nxt;
            if (start_beat) begin
                kw_big            <= block_size;
                bank_big[wr_bank] <= block_size;
                widx              <= ADDR_W'(1);
                pi                <= g0_new;                         // pi(1) = g(0)
                g                 <= mod_add(g0_new, d_new, k_new);  // g(1)
            end else if (run_beat) begin
                widx <= widx + ADDR_W'(1);
                pi   <= mod_add(pi, g, kw);
                g    <= mod_add(g, dw, kw);
                if (last_beat)
                    wr_bank <= ~wr_bank;
            end

            if ((rstate == R_IDLE) && full[rd_bank]) begin
                kr_big <= bank_big[rd_bank];
                raddr  <= '0;
            end else if (rstate == R_RUN) begin
                raddr <= raddr + ADDR_W'(1);
                if (rd_last)
                    rd_bank <= ~rd_bank;
            end
        end
    end

    // ---------------- stage p1/p2: read-data qualifiers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            sop_p1  <= 1'b0;
            eop_p1  <= 1'b0;
            done_p2 <= 1'b0;
        end else begin
            vld_p1  <= rd_en;
            sop_p1  <= rd_en & (raddr == '0);
            eop_p1  <= rd_last;
            done_p2 <= eop_p1;
        end
    end

    assign out_valid = vld_p1;
    assign out_start = sop_p1;
    assign out_end   = eop_p1;
    assign done      = done_p2;
    assign wstate_w  = wstate;
    assign rstate_w  = rstate;

`ifdef DEINT_OVF_FLAG_EN
    logic ovf_flag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovf_flag <= 1'b0;
        else if ((in_valid & ~ready) | (in_valid & in_start & (wstate == W_RUN)))
            ovf_flag <= 1'b1;
    end

    assign ovf = ovf_flag;
`endif

endmodule

// File: tb/tb_deinterleaver_fsm.sv
// -----------------------------------------------------------------------------
// tb_deinterleaver_fsm
//
// Testbench for deinterleaver_fsm. The reference model computes pi(i) in
// closed form as (f1*i + f2*i^2) mod K. It tracks completed blocks in a queue
// and follows ping-pong bank use. One compare process checks every output on
// each falling edge. The directed tests also check hand-computed literal
// values.
// -----------------------------------------------------------------------------
module tb_deinterleaver_fsm;

    localparam int ADDR_W = 13;

    logic              clk = 1'b0;
    logic              reset;
    logic              block_size;
    logic              in_start;
    logic              in_valid;
    logic              ready;
    logic              wr_en;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_en;
    logic              rd_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic              out_valid;
    logic              out_start;
    logic              out_end;
    logic              done;
    logic [1:0]        wstate_w;
    logic [1:0]        rstate_w;
`ifdef DEINT_OVF_FLAG_EN
    logic              ovf;
`endif

    always #5 clk = ~clk;

    deinterleaver_fsm #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .block_size (block_size),
        .in_start   (in_start),
        .in_valid   (in_valid),
        .ready      (ready),
        .wr_en      (wr_en),
        .wr_bank    (wr_bank),
        .wr_addr    (wr_addr),
        .rd_en      (rd_en),
        .rd_bank    (rd_bank),
        .rd_addr    (rd_addr),
        .out_valid  (out_valid),
        .out_start  (out_start),
        .out_end    (out_end),
        .done       (done),
        .wstate_w   (wstate_w),
        .rstate_w   (rstate_w)
`ifdef DEINT_OVF_FLAG_EN
        ,
        .ovf        (ovf)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Closed-form QPP permutation.
    function automatic int qpp(input int i, input int k);
        longint f1, f2, li;
        f1 = (k == 6144) ? 263 : 17;
        f2 = (k == 6144) ? 480 : 66;
        li = i;
        return int'((f1 * li + f2 * li * li) % k);
    endfunction

    // ---------------- reference model state ----------------
    bit  m_run, m_bank, m_rbank, m_ovf;
    int  m_idx, m_K, occ, bm_cnt;
    bit  bitmap [6144];
    int  q_k [$];
    bit  r_act;
    int  r_addr, r_K, gap;
    bit  e_v, e_s, e_e, e_d;
    int  o_cnt, o_K, done_cnt, drop_cnt;
    int  blk_out [$];
    int  wbank_hist [$];
    int  wr_first [3];

    function automatic bit model_idle();
        return (q_k.size() == 0) && !r_act && !e_v && !e_e && !e_d;
    endfunction

    always @(negedge clk) begin
        bit exp_wr, cyc_rd, n_s, n_e;
        int idx, k, exp_rs;
        if (reset) begin
            chk("reset_outputs", {ready, wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr,
                                  out_valid, out_start, out_end, done, wstate_w, rstate_w}, 0);
            m_run = 0; m_bank = 0; m_rbank = 0; m_ovf = 0; m_idx = 0; m_K = 1056;
            occ = 0; bm_cnt = 0; q_k.delete(); r_act = 0; r_addr = 0; r_K = 1056; gap = 0;
            e_v = 0; e_s = 0; e_e = 0; e_d = 0; o_cnt = 0; o_K = 0;
        end else begin
            // writer side
            chk("ready", ready, (occ < 2));
            exp_wr = in_valid && ready && (in_start || m_run);
            chk("wr_en", wr_en, exp_wr);
            chk("wr_bank", wr_bank, m_bank);
            chk("wstate_run", (wstate_w == 2'd1), m_run);
            if (in_valid && !ready)
                drop_cnt++;
`ifdef DEINT_OVF_FLAG_EN
            chk("ovf", ovf, m_ovf);
            if ((in_valid && !ready) || (in_valid && in_start && m_run))
                m_ovf = 1;
`endif
            if (exp_wr) begin
                if (in_start) begin
                    k = block_size ? 6144 : 1056;
                    idx = 0;
                    m_K = k;
                    m_run = 1;
                    foreach (bitmap[j]) bitmap[j] = 0;
                    bm_cnt = 0;
                end else begin
                    k = m_K;
                    idx = m_idx;
                end
                chk("wr_addr", wr_addr, qpp(idx, k));
                if (idx < 3)
                    wr_first[idx] = int'(wr_addr);
                if (int'(wr_addr) < k && !bitmap[wr_addr]) begin
                    bitmap[wr_addr] = 1;
                    bm_cnt++;
                end
                m_idx = idx + 1;
                if (m_idx == k) begin
                    chk("block_coverage", bm_cnt, k);
                    q_k.push_back(k);
                    wbank_hist.push_back(int'(m_bank));
                    m_bank = !m_bank;
                    m_run = 0;
                    occ++;
                end
            end

            // reader side
            if (!r_act && rd_en && q_k.size() > 0) begin
                r_act = 1;
                r_K = q_k.pop_front();
                r_addr = 0;
                o_K = r_K;
                o_cnt = 0;
                gap = 0;
            end
            chk("rd_bank", rd_bank, m_rbank);
            cyc_rd = r_act;
            n_s = 0;
            n_e = 0;
            if (r_act) begin
                chk("rd_en", rd_en, 1);
                chk("rd_addr", rd_addr, r_addr);
                n_s = (r_addr == 0);
                n_e = (r_addr == r_K - 1);
                r_addr++;
                if (n_e) begin
                    r_act = 0;
                    occ--;
                    m_rbank = !m_rbank;
                end
            end else begin
                chk("rd_en", rd_en, 0);
                if (q_k.size() > 0) begin
                    gap++;
                    chk("read_gap_le2", (gap <= 2), 1);
                end else begin
                    gap = 0;
                end
            end
            exp_rs = cyc_rd ? 1 : (e_e ? 2 : 0);
            chk("rstate", rstate_w, exp_rs);

            // read-data qualifiers
            chk("out_valid", out_valid, e_v);
            chk("out_start", out_start, e_s);
            chk("out_end", out_end, e_e);
            chk("done", done, e_d);
            if (out_valid)
                o_cnt++;
            if (e_e) begin
                chk("out_count", o_cnt, o_K);
                blk_out.push_back(o_cnt);
            end
            if (done)
                done_cnt++;
            e_d = e_e;
            e_v = cyc_rd;
            e_s = n_s;
            e_e = n_e;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_blocks(input int nb, input logic [7:0] sizes,
                                input int abort_at, input int stop_at);
        int  b, n, tot, k, guard;
        bit  aborted;
        b = 0; n = 0; tot = 0; guard = 0; aborted = 0;
        k = sizes[0] ? 6144 : 1056;
        while (b < nb && guard < 40000) begin
            if (abort_at > 0 && !aborted && b == 0 && n == abort_at) begin
                n = 0;
                aborted = 1;
            end
            if (stop_at > 0 && tot == stop_at)
                break;
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_start = (n == 0);
            // block_size only matters on the start beat; drive the opposite value otherwise
            block_size = (n == 0) ? sizes[b] : ~sizes[b];
            @(negedge clk);
            guard++;
            if (ready) begin
                n++;
                tot++;
                if (n == k) begin
                    b++;
                    n = 0;
                    if (b < nb)
                        k = sizes[b] ? 6144 : 1056;
                end
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_start = 1'b0;
        chk("drive_budget", (guard < 40000), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!model_idle() && n < 30000);
        chk("idle_timeout", (n >= 30000), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        int d0, n_drop, nb;
        reset = 1'b1; block_size = 1'b0; in_start = 1'b0; in_valid = 1'b0;
        done_cnt = 0; drop_cnt = 0;
        // model constants pinned by hand
        chk("qpp_1056_1", qpp(1, 1056), 83);
        chk("qpp_1056_2", qpp(2, 1056), 298);
        chk("qpp_6144_1", qpp(1, 6144), 743);
        chk("qpp_6144_2", qpp(2, 6144), 2446);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // test 1: single K=1056 block, preceded by a stray beat without in_start
        @(posedge clk); #1;
        in_valid = 1'b1; in_start = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        d0 = done_cnt;
        drive_blocks(1, 8'h00, 0, 0);
        wait_idle();
        chk("t1_addr0", wr_first[0], 0);
        chk("t1_addr1", wr_first[1], 83);
        chk("t1_addr2", wr_first[2], 298);
        chk("t1_out_beats", blk_out[blk_out.size()-1], 1056);
        chk("t1_done_pulses", done_cnt - d0, 1);

        // test 2: K=6144 block
        drive_blocks(1, 8'h01, 0, 0);
        wait_idle();
        chk("t2_addr0", wr_first[0], 0);
        chk("t2_addr1", wr_first[1], 743);
        chk("t2_addr2", wr_first[2], 2446);
        chk("t2_out_beats", blk_out[blk_out.size()-1], 6144);

        // test 3: in_start reasserted after 500 beats
`ifdef DEINT_OVF_FLAG_EN
        chk("t3_ovf_before", ovf, 0);
`endif
        nb = blk_out.size();
        drive_blocks(1, 8'h00, 500, 0);
        wait_idle();
        chk("t3_blocks_out", blk_out.size() - nb, 1);
        chk("t3_out_beats", blk_out[blk_out.size()-1], 1056);
`ifdef DEINT_OVF_FLAG_EN
        chk("t3_ovf_after", ovf, 1);
`endif

        // test 4: async reset mid-write and mid-read
        do_reset();
        drive_blocks(2, 8'h00, 0, 1056 + 300);
        @(negedge clk); #1;
        chk("t4_mid_write", wstate_w, 1);
        chk("t4_mid_read", rstate_w, 1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("t4_async_clear", {ready, wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr,
                               out_valid, out_start, out_end, done, wstate_w, rstate_w}, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        nb = blk_out.size();
        drive_blocks(1, 8'h00, 0, 0);
        wait_idle();
        chk("t4_blocks_out", blk_out.size() - nb, 1);
        chk("t4_out_beats", blk_out[blk_out.size()-1], 1056);
`ifdef DEINT_OVF_FLAG_EN
        chk("t4_ovf_cleared", ovf, 0);
`endif

        // test 5: three back-to-back K=1056 blocks from a clean reset
        do_reset();
        n_drop = drop_cnt;
        nb = blk_out.size();
        drive_blocks(3, 8'h00, 0, 0);
        wait_idle();
        chk("t5_ready_dropped", (drop_cnt > n_drop), 1);
        chk("t5_bank_a", wbank_hist[wbank_hist.size()-3], 0);
        chk("t5_bank_b", wbank_hist[wbank_hist.size()-2], 1);
        chk("t5_bank_c", wbank_hist[wbank_hist.size()-1], 0);
        chk("t5_blocks_out", blk_out.size() - nb, 3);
        for (int j = 1; j <= 3; j++)
            chk("t5_out_beats", blk_out[blk_out.size()-j], 1056);

        // test 6: mixed sizes, 1056 then 6144
        drive_blocks(2, 8'h02, 0, 0);
        wait_idle();
        chk("t6_first_beats", blk_out[blk_out.size()-2], 1056);
        chk("t6_second_beats", blk_out[blk_out.size()-1], 6144);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
